// File: rtl/isp_frame_window_ctrl.sv
// Raw-frame window sequencer: tracks the pixel position in the raw frame,
// crops a WIN_W x WIN_H window and tags each output pixel with its Bayer
// phase. Window origin and Bayer pattern change only at frame boundaries.
module isp_frame_window_ctrl #(
    parameter int          DATA_W     = 8,
    parameter int          RAW_HPIXEL = 1936,
    parameter int          RAW_VPIXEL = 1088,
    parameter int          WIN_W      = 640,
    parameter int          WIN_H      = 480,
    parameter int          WIN_X_DEF  = 500,
    parameter int          WIN_Y_DEF  = 500,
    parameter logic [1:0]  BAYER_DEF  = 2'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ctrl_en,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              cfg_valid,
    input  logic [10:0]       cfg_win_x,
    input  logic [10:0]       cfg_win_y,
    input  logic [1:0]        cfg_bayer,
    output logic              cfg_ready,
    output logic              cfg_err,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_phase,
    output logic              out_sof,
    output logic              out_eol,
    output logic              out_eof,
    output logic              busy,
    output logic [15:0]       frame_cnt
);

    localparam logic [10:0] H_LAST  = 11'(RAW_HPIXEL - 1);
    localparam logic [10:0] V_LAST  = 11'(RAW_VPIXEL - 1);
    localparam logic [11:0] RAW_W12 = 12'(RAW_HPIXEL);
    localparam logic [11:0] RAW_H12 = 12'(RAW_VPIXEL);
    localparam logic [11:0] WIN_W12 = 12'(WIN_W);
    localparam logic [11:0] WIN_H12 = 12'(WIN_H);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [10:0]         h_cnt_q, h_cnt_d;
    logic [10:0]         v_cnt_q, v_cnt_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;

    // Active configuration (used by the window logic) and the pending slot.
    logic [10:0]         win_x_q, win_x_d;
    logic [10:0]         win_y_q, win_y_d;
    logic [1:0]          bayer_q, bayer_d;
    logic                pend_q, pend_d;
    logic [10:0]         pend_x_q, pend_x_d;
    logic [10:0]         pend_y_q, pend_y_d;
    logic [1:0]          pend_bayer_q, pend_bayer_d;
    logic                cfg_err_q, cfg_err_d;

    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [1:0]          out_phase_q, out_phase_d;
    logic                out_sof_q, out_sof_d;
    logic                out_eol_q, out_eol_d;
    logic                out_eof_q, out_eof_d;

    // Shared decode used by the FSM, counters and config logic.
    logic                cnt_en;
    logic                frame_end;
    logic                cfg_acc;
    logic                cfg_fits;
    logic [11:0]         cfg_x_end, cfg_y_end;
    logic [11:0]         h_ext, v_ext;
    logic [11:0]         win_x_ext, win_y_ext;
    logic [11:0]         win_x_last, win_y_last;
    logic                in_win;

    assign cnt_en    = (state_q != IDLE) && in_valid;
    assign frame_end = cnt_en && (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);

    // The slot is free whenever nothing is pending, so acceptance needs no
    // extra arbitration against the frame-boundary apply.
    assign cfg_acc   = cfg_valid && !pend_q;
    assign cfg_x_end = {1'b0, cfg_win_x} + WIN_W12;
    assign cfg_y_end = {1'b0, cfg_win_y} + WIN_H12;
    assign cfg_fits  = (cfg_x_end <= RAW_W12) && (cfg_y_end <= RAW_H12);

    assign h_ext      = {1'b0, h_cnt_q};
    assign v_ext      = {1'b0, v_cnt_q};
    assign win_x_ext  = {1'b0, win_x_q};
    assign win_y_ext  = {1'b0, win_y_q};
    assign win_x_last = win_x_ext + WIN_W12 - 12'd1;
    assign win_y_last = win_y_ext + WIN_H12 - 12'd1;
    assign in_win     = cnt_en
                     && (h_ext >= win_x_ext) && (h_ext <= win_x_last)
                     && (v_ext >= win_y_ext) && (v_ext <= win_y_last);

    // Run-state sequencing: STOP lets the current frame complete before IDLE.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first so
        // no path through the case leaves it unassigned and infers a latch.
        state_d = state_q;
        unique case (state_q)
            IDLE: if (ctrl_en) state_d = RUN;
            RUN:  if (!ctrl_en) state_d = frame_end ? IDLE : STOP;
            STOP: begin
                if (ctrl_en)        state_d = RUN;
                else if (frame_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Raw-frame position counters and the completed-frame counter.
    always_comb begin
        h_cnt_d     = h_cnt_q;
        v_cnt_d     = v_cnt_q;
        frame_cnt_d = frame_cnt_q;
        if (state_q == IDLE) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (cnt_en) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? 11'd0 : v_cnt_q + 11'd1;
            end else begin
                h_cnt_d = h_cnt_q + 11'd1;
            end
        end
        if (frame_end) frame_cnt_d = frame_cnt_q + 16'd1;
    end

    // Config handshake: reject, apply now (IDLE), or park until frame end.
    always_comb begin
        win_x_d      = win_x_q;
        win_y_d      = win_y_q;
        bayer_d      = bayer_q;
        pend_d       = pend_q;
        pend_x_d     = pend_x_q;
        pend_y_d     = pend_y_q;
        pend_bayer_d = pend_bayer_q;
        cfg_err_d    = 1'b0;
        if (frame_end && pend_q) begin
            win_x_d = pend_x_q;
            win_y_d = pend_y_q;
            bayer_d = pend_bayer_q;
            pend_d  = 1'b0;
        end
        // A request taken on a boundary cycle sees pend_q=0 here, so it is
        // parked and only applied at the following boundary.
        if (cfg_acc) begin
            if (!cfg_fits) begin
                cfg_err_d = 1'b1;
            end else if (state_q == IDLE) begin
                win_x_d = cfg_win_x;
                win_y_d = cfg_win_y;
                bayer_d = cfg_bayer;
            end else begin
                pend_d       = 1'b1;
                pend_x_d     = cfg_win_x;
                pend_y_d     = cfg_win_y;
                pend_bayer_d = cfg_bayer;
            end
        end
    end

    // Window crop and marker generation, registered with the pixel.
    always_comb begin
        out_valid_d = in_win;
        out_data_d  = in_win ? in_data : '0;
        out_phase_d = in_win ? (bayer_q ^ {v_cnt_q[0], h_cnt_q[0]}) : 2'b00;
        out_sof_d   = in_win && (h_cnt_q == win_x_q) && (v_cnt_q == win_y_q);
        out_eol_d   = in_win && (h_ext == win_x_last);
        out_eof_d   = out_eol_d && (v_ext == win_y_last);
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (rst) begin
            state_q      <= IDLE;
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            frame_cnt_q  <= '0;
            win_x_q      <= 11'(WIN_X_DEF);
            win_y_q      <= 11'(WIN_Y_DEF);
            bayer_q      <= BAYER_DEF;
            pend_q       <= 1'b0;
            pend_x_q     <= '0;
            pend_y_q     <= '0;
            pend_bayer_q <= '0;
            cfg_err_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_phase_q  <= '0;
            out_sof_q    <= 1'b0;
            out_eol_q    <= 1'b0;
            out_eof_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            win_x_q      <= win_x_d;
            win_y_q      <= win_y_d;
            bayer_q      <= bayer_d;
            pend_q       <= pend_d;
            pend_x_q     <= pend_x_d;
            pend_y_q     <= pend_y_d;
            pend_bayer_q <= pend_bayer_d;
            cfg_err_q    <= cfg_err_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_phase_q  <= out_phase_d;
            out_sof_q    <= out_sof_d;
            out_eol_q    <= out_eol_d;
            out_eof_q    <= out_eof_d;
        end
    end

    assign cfg_ready = !pend_q;
    assign cfg_err   = cfg_err_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_phase = out_phase_q;
    assign out_sof   = out_sof_q;
    assign out_eol   = out_eol_q;
    assign out_eof   = out_eof_q;
    assign busy      = (state_q != IDLE);
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_isp_frame_window_ctrl.sv
// Scoreboard bench for isp_frame_window_ctrl on an 8x6 raw frame with a 4x2
// window. The driver pushes the expected output for every window pixel; the
// monitor pops and compares whenever out_valid is seen.
module tb_isp_frame_window_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ctrl_en;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        cfg_valid;
    logic [10:0] cfg_win_x;
    logic [10:0] cfg_win_y;
    logic [1:0]  cfg_bayer;
    logic        cfg_ready;
    logic        cfg_err;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_phase;
    logic        out_sof;
    logic        out_eol;
    logic        out_eof;
    logic        busy;
    logic [15:0] frame_cnt;

    typedef struct {
        int         edge_no;
        logic [7:0] data;
        logic [1:0] phase;
        logic       sof;
        logic       eol;
        logic       eof;
    } exp_t;

    exp_t exp_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    isp_frame_window_ctrl #(
        .DATA_W    (8),
        .RAW_HPIXEL(8),
        .RAW_VPIXEL(6),
        .WIN_W     (4),
        .WIN_H     (2),
        .WIN_X_DEF (2),
        .WIN_Y_DEF (3),
        .BAYER_DEF (2'd0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ctrl_en  (ctrl_en),
        .in_valid (in_valid),
        .in_data  (in_data),
        .cfg_valid(cfg_valid),
        .cfg_win_x(cfg_win_x),
        .cfg_win_y(cfg_win_y),
        .cfg_bayer(cfg_bayer),
        .cfg_ready(cfg_ready),
        .cfg_err  (cfg_err),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_phase(out_phase),
        .out_sof  (out_sof),
        .out_eol  (out_eol),
        .out_eof  (out_eof),
        .busy     (busy),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Present raw pixel idx on the next cycle; push its expected output if it
    // falls inside the window (wx, wy) with pattern bay.
    task automatic drive_pixel(input int idx, input int wx, input int wy, input logic [1:0] bay);
        int   h;
        int   v;
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'(idx);
        h = idx % 8;
        v = idx / 8;
        if (h >= wx && h <= wx + 3 && v >= wy && v <= wy + 1) begin
            e.edge_no = cyc + 1;
            e.data    = 8'(idx);
            e.phase   = bay ^ {v[0], h[0]};
            e.sof     = (h == wx) && (v == wy);
            e.eol     = (h == wx + 3);
            e.eof     = (h == wx + 3) && (v == wy + 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic run_frame(input bit gapped, input int wx, input int wy, input logic [1:0] bay);
        for (int i = 0; i < 48; i++) begin
            drive_pixel(i, wx, wy, bay);
            if (gapped) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_data  = 8'hA5;
            end
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    // Monitor: sample just after each rising edge and compare against the queue.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", {24'd0, out_data}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("out_latency", cyc, e.edge_no);
                    check("out_data", {24'd0, out_data}, {24'd0, e.data});
                    check("out_phase", {30'd0, out_phase}, {30'd0, e.phase});
                    check("out_markers", {29'd0, out_sof, out_eol, out_eof},
                          {29'd0, e.sof, e.eol, e.eof});
                end
            end else begin
                check("idle_outputs", {21'd0, out_data, out_sof, out_eol, out_eof}, 32'd0);
            end
        end
    end

    initial begin : stimulus
        rst       = 1'b1;
        ctrl_en   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        cfg_valid = 1'b0;
        cfg_win_x = '0;
        cfg_win_y = '0;
        cfg_bayer = '0;
        repeat (3) @(negedge clk);
        check("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        check("rst_cfg_err",   {31'd0, cfg_err},   32'd0);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        rst = 1'b0;

        // Normal frame; the pixel presented as ctrl_en rises must be ignored.
        @(negedge clk);
        ctrl_en  = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'd99;
        run_frame(1'b0, 2, 3, 2'd0);
        idle_cycle();
        check("f1_frame_cnt", {16'd0, frame_cnt}, 32'd1);
        check("f1_busy",      {31'd0, busy},      32'd1);

        // Gapped frame: identical outputs, each one cycle after its pixel.
        run_frame(1'b1, 2, 3, 2'd0);
        check("f2_frame_cnt", {16'd0, frame_cnt}, 32'd2);

        // Stop request mid-frame: the frame completes, then IDLE.
        for (int i = 0; i < 48; i++) begin
            drive_pixel(i, 2, 3, 2'd0);
            if (i == 20) ctrl_en = 1'b0;
            if (i == 47) check("stop_busy_last_pixel", {31'd0, busy}, 32'd1);
        end
        idle_cycle();
        check("stop_busy_fall",  {31'd0, busy},      32'd0);
        check("stop_frame_cnt",  {16'd0, frame_cnt}, 32'd3);

        // Pixels while IDLE are ignored.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'd26;
        end
        idle_cycle();

        // Bayer pattern 2 loaded in IDLE takes effect immediately.
        check("idle_cfg_ready_pre", {31'd0, cfg_ready}, 32'd1);
        cfg_valid = 1'b1;
        cfg_win_x = 11'd2;
        cfg_win_y = 11'd3;
        cfg_bayer = 2'd2;
        @(negedge clk);
        cfg_valid = 1'b0;
        check("idle_cfg_ready_post", {31'd0, cfg_ready}, 32'd1);
        check("idle_cfg_err",        {31'd0, cfg_err},   32'd0);
        ctrl_en = 1'b1;
        run_frame(1'b0, 2, 3, 2'd2);

        // Invalid configs (x too large, then y too large) during RUN.
        for (int i = 0; i < 48; i++) begin
            drive_pixel(i, 2, 3, 2'd2);
            if (i == 5) begin
                cfg_valid = 1'b1;
                cfg_win_x = 11'd5;
                cfg_win_y = 11'd0;
                cfg_bayer = 2'd1;
            end
            if (i == 6) begin
                cfg_valid = 1'b0;
                check("bad_x_cfg_err",   {31'd0, cfg_err},   32'd1);
                check("bad_x_cfg_ready", {31'd0, cfg_ready}, 32'd1);
            end
            if (i == 7) check("bad_x_err_pulse", {31'd0, cfg_err}, 32'd0);
            if (i == 15) begin
                cfg_valid = 1'b1;
                cfg_win_x = 11'd0;
                cfg_win_y = 11'd5;
            end
            if (i == 16) begin
                cfg_valid = 1'b0;
                check("bad_y_cfg_err", {31'd0, cfg_err}, 32'd1);
            end
        end

        // Mid-frame config (0,0): current frame keeps (2,3).
        for (int i = 0; i < 48; i++) begin
            drive_pixel(i, 2, 3, 2'd2);
            if (i == 10) begin
                check("mid_cfg_ready_pre", {31'd0, cfg_ready}, 32'd1);
                cfg_valid = 1'b1;
                cfg_win_x = 11'd0;
                cfg_win_y = 11'd0;
                cfg_bayer = 2'd2;
            end
            if (i == 11) begin
                cfg_valid = 1'b0;
                check("mid_cfg_ready_held", {31'd0, cfg_ready}, 32'd0);
            end
            if (i == 47) check("mid_cfg_ready_boundary", {31'd0, cfg_ready}, 32'd0);
        end

        // New window (0,0); a config accepted on the boundary cycle waits a frame.
        for (int i = 0; i < 48; i++) begin
            drive_pixel(i, 0, 0, 2'd2);
            if (i == 0) check("mid_cfg_ready_back", {31'd0, cfg_ready}, 32'd1);
            if (i == 47) begin
                cfg_valid = 1'b1;
                cfg_win_x = 11'd2;
                cfg_win_y = 11'd3;
                cfg_bayer = 2'd0;
            end
        end
        for (int i = 0; i < 48; i++) begin
            drive_pixel(i, 0, 0, 2'd2);
            if (i == 0) begin
                cfg_valid = 1'b0;
                check("edge_cfg_pending", {31'd0, cfg_ready}, 32'd0);
            end
            if (i == 47) check("edge_cfg_still_pending", {31'd0, cfg_ready}, 32'd0);
        end

        // Partial frame with a pending config, then reset mid-frame.
        for (int i = 0; i < 28; i++) begin
            drive_pixel(i, 2, 3, 2'd0);
            if (i == 0) check("edge_cfg_applied_ready", {31'd0, cfg_ready}, 32'd1);
            if (i == 10) begin
                cfg_valid = 1'b1;
                cfg_win_x = 11'd0;
                cfg_win_y = 11'd0;
            end
            if (i == 11) cfg_valid = 1'b0;
            if (i == 20) begin
                check("pre_rst_frame_cnt",  {16'd0, frame_cnt}, 32'd8);
                check("pre_rst_cfg_ready",  {31'd0, cfg_ready}, 32'd0);
            end
        end
        // Pixel 28 is inside the window but reset suppresses its output.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'd28;
        rst      = 1'b1;
        ctrl_en  = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_busy",      {31'd0, busy},      32'd0);
        check("mid_rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        check("mid_rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        rst = 1'b0;

        // After reset the default window is back and the pending config is gone.
        @(negedge clk);
        ctrl_en = 1'b1;
        run_frame(1'b0, 2, 3, 2'd0);
        idle_cycle();
        check("post_rst_frame_cnt", {16'd0, frame_cnt}, 32'd1);
        check("post_rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/isp_frame_window_ctrl.md
Name: isp_frame_window_ctrl

Overview:
- Sequencer placed between the sensor/raw front-end and the demosaic/HDMI path.
- Tracks pixel position in the raw frame (RAW_HPIXEL x RAW_VPIXEL). Qualified pixels are counted on in_valid.
- Generates the Bayer phase for the demosaic stage and crops a WIN_W x WIN_H output window.
- Window origin and Bayer pattern come from a config handshake. New values are applied only at frame boundaries, so a frame never tears.

Parameters:
- DATA_W, 8: pixel data width, pass-through.
- RAW_HPIXEL, 1936: raw pixels per line.
- RAW_VPIXEL, 1088: raw lines per frame.
- WIN_W, 640: crop width.
- WIN_H, 480: crop height.
- WIN_X_DEF, 500: reset window x origin.
- WIN_Y_DEF, 500: reset window y origin.
- BAYER_DEF, 2'd0: reset Bayer pattern (0 RGGB, 1 GRBG, 2 GBRG, 3 BGGR).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ctrl_en  in  1  run request.
- in_valid  in  1  raw pixel qualifier.
- in_data  in  DATA_W  raw pixel.
- cfg_valid  in  1  config request.
- cfg_win_x  in  11  new window x origin.
- cfg_win_y  in  11  new window y origin.
- cfg_bayer  in  2  new Bayer pattern.
- cfg_ready  out  1  config slot free.
- cfg_err  out  1  1-cycle pulse, config rejected.
- out_valid  out  1  cropped pixel valid.
- out_data  out  DATA_W  cropped pixel.
- out_phase  out  2  Bayer phase of out_data pixel: {row_odd, col_odd} XOR-adjusted by the active pattern.
- out_sof  out  1  first window pixel.
- out_eol  out  1  last pixel of a window line.
- out_eof  out  1  last window pixel.
- busy  out  1  state != IDLE.
- frame_cnt  out  16  completed raw frames.

Behaviour:
- Reset: state IDLE; h_cnt=v_cnt=0; active config = defaults; no pending config; cfg_ready=1. All other outputs 0.
- Reset mid-frame: pending config is discarded and counters are cleared on the next edge.
- Timing: counters, config and window logic run on one clock domain with no combinational path from inputs to outputs.
- States: IDLE, RUN, STOP.
  - IDLE: in_valid is ignored. ctrl_en=1 moves to RUN with h_cnt=v_cnt=0. The next in_valid pixel is raw (0,0).
  - RUN: each in_valid increments h_cnt. At h_cnt=RAW_HPIXEL-1, h_cnt wraps to 0 and v_cnt increments. At (RAW_HPIXEL-1, RAW_VPIXEL-1), both wrap to 0 (frame boundary).
  - ctrl_en=0 during RUN moves to STOP. The current frame still finishes. ctrl_en returning to 1 during STOP moves back to RUN with no discontinuity.
  - STOP: counts like RUN. At the frame boundary it goes to IDLE.
- Frame boundary actions: frame_cnt increments (16-bit, wraps); any pending config becomes active.
- Window hit: in_valid & h_cnt in [win_x, win_x+WIN_W-1] & v_cnt in [win_y, win_y+WIN_H-1], using the active config.
- Output latency: 1 cycle.
  - out_valid is the registered window hit.
  - out_data is the registered in_data, or 0 when out_valid=0.
  - out_phase = active_bayer ^ {v_cnt[0], h_cnt[0]}, registered with the pixel.
- Markers (each asserted only together with out_valid):
  - out_sof at (win_x, win_y).
  - out_eol at h_cnt = win_x+WIN_W-1.
  - out_eof at (win_x+WIN_W-1, win_y+WIN_H-1). out_eol also asserts here.
- Config handshake: a request is accepted on cfg_valid & cfg_ready.
  - Validity rule: accepted only if cfg_win_x+WIN_W <= RAW_HPIXEL and cfg_win_y+WIN_H <= RAW_VPIXEL. Sums are computed at 12 bits.
  - Accepted and invalid: cfg_err pulses next cycle; nothing is stored; cfg_ready stays 1.
  - Accepted and valid in IDLE: becomes active next cycle.
  - Accepted and valid in RUN/STOP: held as pending; cfg_ready=0 until the next frame boundary applies it. cfg_ready returns to 1 on the cycle after the boundary.
  - Acceptance on the same cycle as a frame boundary: the pending config applies at the following boundary, not this one.
- Simultaneous events: an in_valid pixel on the cycle ctrl_en rises in IDLE is ignored.

Test Plan:
- Setup for all scenarios: RAW 8x6, WIN 4x2, defaults X=2, Y=3, BAYER=0.
- Normal frame: ctrl_en=1, 48 valid pixels with data=index -> 8 out_valid, data {26..29,34..37}; out_sof with 26; out_eol with 29 and 37; out_eof with 37; frame_cnt=1.
- Gapped input: same frame with in_valid toggling 1/0 -> identical output sequence; each output 1 cycle after its input pixel.
- Bayer phase: cfg_bayer=2 in IDLE, run a frame -> out_phase for pixel 26 (h2,v3) = 2^{1,0} = 0, for pixel 27 = 1.
- Mid-frame config: cfg (X=0,Y=0) at pixel 10 -> cfg_ready=0 until the boundary; frame 1 still crops at (2,3); frame 2 outputs {0..3,8..11}.
- Invalid config: cfg_win_x=5 -> cfg_err=1 for one cycle, window unchanged.
- Stop and reset: ctrl_en=0 at pixel 20 -> frame completes, busy falls after pixel 47, frame_cnt=1. rst asserted mid-frame -> all outputs 0 next cycle, frame_cnt=0.
